duty_ramp_controller: RTL
=========================

Name: duty_ramp_controller

Overview:
Upstream stage of the PWM generator. It accepts target duty commands (0..255 steps) over a valid/ready handshake and ramps its step_count output toward the target by a bounded increment. Updates occur only on PWM period boundaries, so step_count is glitch-free within a period. It drives the PWM generator's 8-bit step-count input directly and provides an emergency-stop path that forces the duty cycle to zero.

Parameters:
PERIOD_CLKS, 10000, clocks per PWM period (1 ms at 10 MHz); legal range 2..16384
RAMP_DIV, 4, PWM periods between ramp steps; legal range 1..255
STEP_INC, 1, step_count change per ramp step; legal range 1..255
MAX_STEP, 255, clamp ceiling for accepted targets (255*39 < 10000)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command strobe
cmd_step  in  8  requested target duty in steps
cmd_ready  out  1  command can be accepted this cycle
estop  in  1  level-sensitive emergency stop
step_count  out  8  current duty in steps, to PWM generator
period_tick  out  1  one-cycle pulse at the last clock of each PWM period
busy  out  1  ramp in progress (RAMP_UP or RAMP_DOWN)
at_target  out  1  step_count == target and not in ESTOP

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: step_count=0, target=0, state=IDLE, period counter=0, prescaler=0, period_tick=0, busy=0, at_target=1, cmd_ready=1.
- Period counter: 14-bit, counts 0..PERIOD_CLKS-1 and wraps. period_tick=1 exactly when counter==PERIOD_CLKS-1, so it is high 1 of every PERIOD_CLKS cycles.
- Prescaler: counts period_ticks 0..RAMP_DIV-1. step_tick=period_tick AND prescaler==RAMP_DIV-1. With RAMP_DIV=1, step_tick=period_tick.
- Handshake: cmd_ready=1 in IDLE, RAMP_UP and RAMP_DOWN; cmd_ready=0 in ESTOP. A command is accepted when cmd_valid && cmd_ready. The registered target becomes min(cmd_step, MAX_STEP) on the next edge. Retargeting mid-ramp is allowed, including reversing direction. No backpressure beyond ESTOP.
- States:
  - IDLE: step_count==target.
  - RAMP_UP: step_count<target.
  - RAMP_DOWN: step_count>target.
  - ESTOP.
  - Outside ESTOP, the registered state is always the comparison of next-cycle step_count and target.
- Ramp step, on step_tick in RAMP_UP: step_count += STEP_INC. If target-step_count < STEP_INC, step_count = target. No overshoot and no 8-bit wrap.
- Ramp step, on step_tick in RAMP_DOWN: step_count -= STEP_INC. If step_count-target < STEP_INC, step_count = target. No underflow.
- step_count never changes except on a step_tick cycle, on estop, or on reset.
- Simultaneous accept and step_tick: the step is computed against the old target. The new target is latched on the same edge, and the state is re-derived from the updated values.
- ESTOP has priority over everything except reset. When estop=1, on the next edge: step_count=0, target=0, prescaler=0, state=ESTOP, busy=0, at_target=0. Commands are ignored.
  - The period counter keeps running, so it stays aligned with the PWM generator.
  - When estop returns to 0, the state goes to IDLE on the next edge with step_count=0 and target=0.
- Reset mid-ramp: all registers return to reset values on the next edge. The PWM generator is reset from the same reset, so the period counters stay aligned.
- busy=(state==RAMP_UP||state==RAMP_DOWN). at_target=(state==IDLE). Both are decoded from registered state.

Decomposition:
- Package duty_ramp_pkg contains:
  - state enum {IDLE, RAMP_UP, RAMP_DOWN, ESTOP}
  - PERIOD_W=14 and STEP_W=8
  - default constants PERIOD_CLKS_DEF=10000 and MAX_STEP_DEF=255
- Sub-module period_ticker contains the period counter and prescaler. Its outputs are period_tick and step_tick, and it has a clear_prescaler input driven by estop.

Test Plan:
Bench parameters: PERIOD_CLKS=10, RAMP_DIV=2, STEP_INC=1 unless stated.
1. Release reset, then hold 50 cycles idle -> step_count=0, at_target=1, busy=0; period_tick pulses at cycles 9, 19, 29, ...
2. Accept cmd_step=3 -> busy=1. step_count goes 1, 2, 3, one increment every 20 cycles and each change aligned to a period_tick edge. Then IDLE with at_target=1.
3. With STEP_INC=4 and step_count=10, accept cmd_step=0 -> step_count goes 6, 2, 0. Final value is 0 with no underflow to 254.
4. During a ramp up toward 200 at step_count=5, accept cmd_step=2 -> state goes to RAMP_DOWN and step_count goes 4, 3, 2. Also drive cmd_valid on the same cycle as a step_tick -> the step uses the old target.
5. Accept cmd_step=255 with MAX_STEP=200 -> target=200 and the ramp ends at 200.
6. Assert estop at step_count=7 -> next edge step_count=0 and cmd_ready=0; cmd_valid is ignored while estop is high. Deassert estop -> IDLE with step_count=0 and cmd_ready=1. Assert reset mid-ramp -> all outputs return to reset values.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// Shared types and constants for the duty ramp controller.
// classify() yields the non-ESTOP state implied by a step_count/target pair.
package duty_ramp_pkg;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, ESTOP} state_t;

  localparam int PERIOD_W        = 14;
  localparam int STEP_W          = 8;
  localparam int PERIOD_CLKS_DEF = 10000;
  localparam int MAX_STEP_DEF    = 255;

  function automatic state_t classify(input logic [STEP_W-1:0] step,
                                      input logic [STEP_W-1:0] target);
    state_t s;
    if (step < target)      s = RAMP_UP;
    else if (step > target) s = RAMP_DOWN;
    else                    s = IDLE;
    return s;
  endfunction

endpackage

// File: rtl/duty_ramp_controller_period_ticker.sv
// PWM period counter plus a prescaler that turns every RAMP_DIV-th period end
// into a ramp step_tick. The period counter is never cleared except by reset.
module period_ticker
  import duty_ramp_pkg::*;
#(
  parameter int PERIOD_CLKS = PERIOD_CLKS_DEF,
  parameter int RAMP_DIV    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_prescaler,
  output logic period_tick,
  output logic step_tick
);

  logic [PERIOD_W-1:0] count_reg;
  logic [7:0]          prescale_reg;

  assign period_tick = (count_reg == PERIOD_W'(PERIOD_CLKS - 1));
  assign step_tick   = period_tick && (prescale_reg == 8'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (period_tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_prescaler) begin
      prescale_reg <= '0;
    end else if (period_tick) begin
      if (prescale_reg == 8'(RAMP_DIV - 1)) prescale_reg <= '0;
      else                                  prescale_reg <= prescale_reg + 8'd1;
    end
  end

endmodule

// File: rtl/duty_ramp_controller.sv
// Ramps step_count toward a commanded target on PWM period boundaries, with a
// level-sensitive emergency stop that forces the duty to zero.
module duty_ramp_controller
  import duty_ramp_pkg::*;
#(
  parameter int PERIOD_CLKS = PERIOD_CLKS_DEF,
  parameter int RAMP_DIV    = 4,
  parameter int STEP_INC    = 1,
  parameter int MAX_STEP    = MAX_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [STEP_W-1:0] cmd_step,
  output logic              cmd_ready,
  input  logic              estop,
  output logic [STEP_W-1:0] step_count,
  output logic              period_tick,
  output logic              busy,
  output logic              at_target
);

  localparam logic [STEP_W-1:0] INC  = STEP_W'(STEP_INC);
  localparam logic [STEP_W-1:0] MAXV = STEP_W'(MAX_STEP);

  state_t            state_reg;
  state_t            state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [STEP_W-1:0] target_reg, target_next;
  logic [STEP_W-1:0] gap_up, gap_down;
  logic              step_tick;

  period_ticker #(
    .PERIOD_CLKS(PERIOD_CLKS),
    .RAMP_DIV   (RAMP_DIV)
  ) u_ticker (
    .clk            (clk),
    .reset          (reset),
    .clear_prescaler(estop),
    .period_tick    (period_tick),
    .step_tick      (step_tick)
  );

  assign gap_up   = target_reg - step_reg;
  assign gap_down = step_reg - target_reg;

  // The step uses the old target; a command accepted on the same edge only
  // affects which state the updated pair classifies into.
  always_comb begin
    step_next   = step_reg;
    target_next = target_reg;
    if (step_tick && state_reg == RAMP_UP)
      step_next = (gap_up < INC) ? target_reg : step_reg + INC;
    else if (step_tick && state_reg == RAMP_DOWN)
      step_next = (gap_down < INC) ? target_reg : step_reg - INC;
    if (cmd_valid && cmd_ready)
      target_next = (cmd_step > MAXV) ? MAXV : cmd_step;
    state_next = classify(step_next, target_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      target_reg <= '0;
    end else if (estop) begin
      state_reg  <= ESTOP;
      step_reg   <= '0;
      target_reg <= '0;
    end else if (state_reg == ESTOP) begin
      state_reg <= IDLE;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      target_reg <= target_next;
    end
  end

  assign step_count = step_reg;
  assign cmd_ready  = (state_reg != ESTOP);
  assign busy       = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);
  assign at_target  = (state_reg == IDLE);

endmodule
